// File: rtl/seg_scan_decoder.sv
// Receive-side monitor for a multiplexed 4-digit seven-segment bus: waits for each
// digit dwell to settle, decodes it back to BCD and publishes complete frames.
module seg_scan_decoder #(
    parameter int SETTLE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] digits,
    output logic [3:0]  digit_err,
    output logic        frame_valid,
    output logic        frame_err
);

    localparam logic [7:0] SETTLE_CNT = 8'(SETTLE);

    typedef enum logic [1:0] {
        IDLE,
        SETTLING,
        HELD
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [6:0]  sampleSeg_q;
    logic [3:0]  sampleAn_q;
    logic [3:0]  mask_q, mask_d;
    logic [15:0] bufVal_q, bufVal_d;
    logic [3:0]  bufErr_q, bufErr_d;
    logic [15:0] digits_q, digits_d;
    logic [3:0]  digitErr_q, digitErr_d;
    logic        frameValid_q, frameValid_d;
    logic        frameErr_q, frameErr_d;

    logic        sampleChanged;
    logic        capture;
    logic [1:0]  slot;
    logic [4:0]  decoded;
    logic [15:0] mergedVal;
    logic [3:0]  mergedErr;
    logic [3:0]  mergedMask;

    function automatic logic isLegal(input logic [3:0] a);
        case (a)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] slotOf(input logic [3:0] a);
        case (a)
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // Result is {err, value}; unknown patterns decode to F with the error flag set.
    function automatic logic [4:0] decodeSeg(input logic [6:0] s);
        case (s)
            7'h7E:   return 5'h00;
            7'h30:   return 5'h01;
            7'h6D:   return 5'h02;
            7'h79:   return 5'h03;
            7'h33:   return 5'h04;
            7'h5B:   return 5'h05;
            7'h5F:   return 5'h06;
            7'h70:   return 5'h07;
            7'h7F:   return 5'h08;
            7'h73:   return 5'h09;
            default: return 5'h1F;
        endcase
    endfunction

    // The raw pins are compared against the sample register, so the dwell restarts
    // on the same edge that loads the new sample.
    always_comb begin
        sampleChanged = ({seg, an} != {sampleSeg_q, sampleAn_q});
        capture       = (state_q == SETTLING) && (cnt_q == SETTLE_CNT);
        slot          = slotOf(sampleAn_q);
        decoded       = decodeSeg(sampleSeg_q);

        mergedVal                   = bufVal_q;
        mergedVal[{slot, 2'b00} +: 4] = decoded[3:0];
        mergedErr                   = bufErr_q;
        mergedErr[slot]             = decoded[4];
        mergedMask                  = mask_q | (4'b0001 << slot);

        state_d      = state_q;
        cnt_d        = cnt_q;
        mask_d       = mask_q;
        bufVal_d     = bufVal_q;
        bufErr_d     = bufErr_q;
        digits_d     = digits_q;
        digitErr_d   = digitErr_q;
        frameValid_d = 1'b0;
        frameErr_d   = 1'b0;

        if (capture) begin
            bufVal_d = mergedVal;
            bufErr_d = mergedErr;
            state_d  = HELD;
            if (mergedMask == 4'b1111) begin
                digits_d     = mergedVal;
                digitErr_d   = mergedErr;
                frameValid_d = 1'b1;
                frameErr_d   = |mergedErr;
                mask_d       = 4'b0000;
            end else begin
                mask_d = mergedMask;
            end
        end

        if (sampleChanged) begin
            if (isLegal(an)) begin
                state_d = SETTLING;
                cnt_d   = 8'd1;
            end else begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        end else if ((state_q == SETTLING) && (cnt_q != SETTLE_CNT)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            sampleSeg_q  <= 7'd0;
            sampleAn_q   <= 4'd0;
            mask_q       <= 4'd0;
            bufVal_q     <= 16'd0;
            bufErr_q     <= 4'd0;
            digits_q     <= 16'd0;
            digitErr_q   <= 4'd0;
            frameValid_q <= 1'b0;
            frameErr_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sampleSeg_q  <= seg;
            sampleAn_q   <= an;
            mask_q       <= mask_d;
            bufVal_q     <= bufVal_d;
            bufErr_q     <= bufErr_d;
            digits_q     <= digits_d;
            digitErr_q   <= digitErr_d;
            frameValid_q <= frameValid_d;
            frameErr_q   <= frameErr_d;
        end
    end

    assign digits      = digits_q;
    assign digit_err   = digitErr_q;
    assign frame_valid = frameValid_q;
    assign frame_err   = frameErr_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: directed dwell sequences push expected frames,
// a negedge monitor pops and compares them whenever frame_valid pulses.
module tb_seg_scan_decoder;

    localparam int SETTLE = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] digits;
    logic [3:0]  digit_err;
    logic        frame_valid;
    logic        frame_err;

    typedef struct {
        logic [15:0] d;
        logic [3:0]  e;
        logic        fe;
        int          edgeNo;
    } exp_t;

    exp_t expQ[$];
    int   checks    = 0;
    int   errors    = 0;
    int   edgeCount = 0;
    bit   prevValid = 1'b0;

    seg_scan_decoder #(.SETTLE(SETTLE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg         (seg),
        .an          (an),
        .digits      (digits),
        .digit_err   (digit_err),
        .frame_valid (frame_valid),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edgeCount++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] a, input logic [6:0] s, input int n);
        an  = a;
        seg = s;
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge just before the completing dwell is driven: that dwell loads
    // at the next edge and the frame pulse is seen SETTLE edges after it.
    task automatic expectFrame(input logic [15:0] d, input logic [3:0] e, input logic fe);
        exp_t x;
        x.d      = d;
        x.e      = e;
        x.fe     = fe;
        x.edgeNo = edgeCount + 1 + SETTLE;
        expQ.push_back(x);
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (rst_n === 1'b1 && frame_valid === 1'b1) begin
            checkOutput("no back-to-back frame_valid", 32'(prevValid), 32'd0);
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected frame: got digits=%h err=%b, expected no frame", digits, digit_err);
            end else begin
                x = expQ.pop_front();
                checkOutput("frame digits", 32'(digits), 32'(x.d));
                checkOutput("frame digit_err", 32'(digit_err), 32'(x.e));
                checkOutput("frame_err", 32'(frame_err), 32'(x.fe));
                checkOutput("frame latency edge", 32'(edgeCount), 32'(x.edgeNo));
            end
        end
        prevValid = (frame_valid === 1'b1);
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        an    = 4'hF;
        seg   = 7'h00;
        #12;
        checkOutput("reset digits", 32'(digits), 32'h0);
        checkOutput("reset digit_err", 32'(digit_err), 32'h0);
        checkOutput("reset frame_valid", 32'(frame_valid), 32'h0);
        checkOutput("reset frame_err", 32'(frame_err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Normal scan 0,1,2,3
        applyStimulus(4'b1110, 7'h7E, 8);
        applyStimulus(4'b1101, 7'h30, 8);
        applyStimulus(4'b1011, 7'h6D, 8);
        expectFrame(16'h3210, 4'b0000, 1'b0);
        applyStimulus(4'b0111, 7'h79, 8);

        // Short glitch on digit 3 must not complete the frame early
        applyStimulus(4'b1110, 7'h7E, 8);
        applyStimulus(4'b1101, 7'h30, 8);
        applyStimulus(4'b1011, 7'h6D, 8);
        applyStimulus(4'b0111, 7'h5B, 3);
        expectFrame(16'h6210, 4'b0000, 1'b0);
        applyStimulus(4'b0111, 7'h5F, 8);

        // Long dwells capture once
        applyStimulus(4'b1110, 7'h33, 100);
        applyStimulus(4'b1101, 7'h5B, 8);
        applyStimulus(4'b1011, 7'h5F, 8);
        expectFrame(16'h7654, 4'b0000, 1'b0);
        applyStimulus(4'b0111, 7'h70, 100);

        // Invalid pattern on digit 2
        applyStimulus(4'b1110, 7'h73, 8);
        applyStimulus(4'b1101, 7'h7F, 8);
        applyStimulus(4'b1011, 7'h00, 8);
        expectFrame(16'h7F89, 4'b0100, 1'b1);
        applyStimulus(4'b0111, 7'h70, 8);

        // Illegal anode selects between dwells
        applyStimulus(4'b1111, 7'h00, 6);
        applyStimulus(4'b1110, 7'h5B, 8);
        applyStimulus(4'b1100, 7'h30, 6);
        applyStimulus(4'b1101, 7'h5F, 8);
        applyStimulus(4'b1111, 7'h7E, 5);
        applyStimulus(4'b1011, 7'h70, 8);
        applyStimulus(4'b1100, 7'h33, 6);
        expectFrame(16'h8765, 4'b0000, 1'b0);
        applyStimulus(4'b0111, 7'h7F, 8);

        // Reset mid-frame discards digits 0 and 1
        applyStimulus(4'b1110, 7'h73, 8);
        applyStimulus(4'b1101, 7'h7F, 8);
        an = 4'b1111;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid reset digits", 32'(digits), 32'h0);
        checkOutput("mid reset digit_err", 32'(digit_err), 32'h0);
        checkOutput("mid reset frame_valid", 32'(frame_valid), 32'h0);
        checkOutput("mid reset frame_err", 32'(frame_err), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4'b1011, 7'h79, 8);
        applyStimulus(4'b0111, 7'h33, 8);
        applyStimulus(4'b1110, 7'h30, 8);
        expectFrame(16'h4321, 4'b0000, 1'b0);
        applyStimulus(4'b1101, 7'h6D, 8);
        applyStimulus(4'b1011, 7'h79, 8);
        applyStimulus(4'b0111, 7'h33, 8);
        applyStimulus(4'b1111, 7'h00, 4);

        repeat (20) @(negedge clk);
        checkOutput("all expected frames seen", 32'(expQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
